wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between three result producers:
  - the in-order pipeline write-back path (ALU / LUI / AUIPC / JAL / JALR result);
  - the load unit, which returns memory data late;
  - the multi-cycle mul/div unit.
- Uses valid/ready handshakes, fixed-priority-with-anti-starvation arbitration and a registered write stage.
- Sits between the execute/memory stages and the register file; its ready signals are the pipeline stall source for write-port conflicts.

---
 rtl/wb_port_arbiter_pkg.sv | 22 ++
 rtl/wb_port_arbiter_if.sv | 44 ++++
 rtl/wb_port_arbiter_wait_counter.sv | 34 +++
 rtl/wb_port_arbiter.sv | 116 +++++++++++
 tb/tb_wb_port_arbiter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared write-back definitions: source codes, default data width, register index width.
package wb_port_arbiter_pkg;

   localparam int unsigned DEF_XLEN = 32;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned SRC_W    = 2;

   // Source of the current register-file write
   typedef enum logic [SRC_W-1:0] {
      WB_SRC_NONE   = 2'd0,
      WB_SRC_PIPE   = 2'd1,
      WB_SRC_LOAD   = 2'd2,
      WB_SRC_MULDIV = 2'd3
   } wb_src_e;

   // Which slow requester wins a tie
   typedef enum logic {
      RR_LOAD   = 1'b0,
      RR_MULDIV = 1'b1
   } rr_ptr_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back bus: three producer handshakes plus the registered register-file write.
//   master : producers (drive valid/rd/data, observe ready and the rf write)
//   slave  : the arbiter
interface wb_port_arbiter_if
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned XLEN = DEF_XLEN
);

   logic             pipe_valid;
   logic [REG_W-1:0] pipe_rd;
   logic [XLEN-1:0]  pipe_data;
   logic             pipe_ready;

   logic             ld_valid;
   logic [REG_W-1:0] ld_rd;
   logic [XLEN-1:0]  ld_data;
   logic             ld_ready;

   logic             md_valid;
   logic [REG_W-1:0] md_rd;
   logic [XLEN-1:0]  md_data;
   logic             md_ready;

   logic             rf_we;
   logic [REG_W-1:0] rf_rd;
   logic [XLEN-1:0]  rf_wdata;
   logic [SRC_W-1:0] wb_src;

   modport master (
      output pipe_valid, pipe_rd, pipe_data, input pipe_ready,
      output ld_valid, ld_rd, ld_data, input ld_ready,
      output md_valid, md_rd, md_data, input md_ready,
      input  rf_we, rf_rd, rf_wdata, wb_src
   );

   modport slave (
      input  pipe_valid, pipe_rd, pipe_data, output pipe_ready,
      input  ld_valid, ld_rd, ld_data, output ld_ready,
      input  md_valid, md_rd, md_data, output md_ready,
      output rf_we, rf_rd, rf_wdata, wb_src
   );

endinterface

// File: rtl/wb_port_arbiter_wait_counter.sv
// Anti-starvation counter for one slow requester.
//   clk, rst_n : clock, async active-low reset
//   valid      : requester is asking for the write port
//   granted    : requester won this cycle
//   forced_c   : requester has waited MAX_WAIT cycles and must win (combinational)
module wb_port_arbiter_wait_counter #(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned WAIT_W   = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic valid,
   input  logic granted,
   output logic forced_c
);

   localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] count;

   // Count refused cycles, saturating; any grant or withdrawal restarts the wait
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!valid || granted) begin
         count <= '0;
      end else if (count != MAX_CNT) begin
         count <= count + WAIT_W'(1);
      end
   end

   assign forced_c = valid && (count == MAX_CNT);

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter for pipeline, load unit and mul/div results.
//   clk, rst_n : clock, async active-low reset
//   bus        : producer handshakes (combinational readies = pipeline stall source)
//                and the registered write stage rf_we/rf_rd/rf_wdata/wb_src
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned XLEN     = DEF_XLEN,
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned WAIT_W   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   wb_port_arbiter_if.slave bus
);

   logic             ld_forced_c;
   logic             md_forced_c;
   logic             grant_pipe_c;
   logic             grant_ld_c;
   logic             grant_md_c;
   wb_src_e          win_src_c;
   logic [REG_W-1:0] win_rd_c;
   logic [XLEN-1:0]  win_data_c;
   rr_ptr_e          rr_ptr;

   wb_port_arbiter_wait_counter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_ld_wait (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid    (bus.ld_valid),
      .granted  (grant_ld_c),
      .forced_c (ld_forced_c)
   );

   wb_port_arbiter_wait_counter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_md_wait (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid    (bus.md_valid),
      .granted  (grant_md_c),
      .forced_c (md_forced_c)
   );

   // Winner select: forced slow requester, then pipe, then slow requesters by rr_ptr
   always_comb begin
      grant_pipe_c = 1'b0;
      grant_ld_c   = 1'b0;
      grant_md_c   = 1'b0;
      if (ld_forced_c || md_forced_c) begin
         if (ld_forced_c && md_forced_c) begin
            grant_ld_c = (rr_ptr == RR_LOAD);
            grant_md_c = (rr_ptr == RR_MULDIV);
         end else begin
            grant_ld_c = ld_forced_c;
            grant_md_c = md_forced_c;
         end
      end else if (bus.pipe_valid) begin
         grant_pipe_c = 1'b1;
      end else if (bus.ld_valid && bus.md_valid) begin
         grant_ld_c = (rr_ptr == RR_LOAD);
         grant_md_c = (rr_ptr == RR_MULDIV);
      end else begin
         grant_ld_c = bus.ld_valid;
         grant_md_c = bus.md_valid;
      end
   end

   // Winner payload mux
   always_comb begin
      win_src_c  = WB_SRC_NONE;
      win_rd_c   = '0;
      win_data_c = '0;
      if (grant_pipe_c) begin
         win_src_c  = WB_SRC_PIPE;
         win_rd_c   = bus.pipe_rd;
         win_data_c = bus.pipe_data;
      end else if (grant_ld_c) begin
         win_src_c  = WB_SRC_LOAD;
         win_rd_c   = bus.ld_rd;
         win_data_c = bus.ld_data;
      end else if (grant_md_c) begin
         win_src_c  = WB_SRC_MULDIV;
         win_rd_c   = bus.md_rd;
         win_data_c = bus.md_data;
      end
   end

   assign bus.pipe_ready = grant_pipe_c;
   assign bus.ld_ready   = grant_ld_c;
   assign bus.md_ready   = grant_md_c;

   // Write stage and round-robin pointer; x0 writes are accepted but never enable the file
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rf_we    <= 1'b0;
         bus.rf_rd    <= '0;
         bus.rf_wdata <= '0;
         bus.wb_src   <= WB_SRC_NONE;
         rr_ptr       <= RR_LOAD;
      end else begin
         bus.wb_src <= win_src_c;
         if (win_src_c != WB_SRC_NONE) begin
            bus.rf_we    <= (win_rd_c != '0);
            bus.rf_rd    <= win_rd_c;
            bus.rf_wdata <= win_data_c;
         end else begin
            bus.rf_we <= 1'b0;
         end
         if (grant_ld_c) begin
            rr_ptr <= RR_MULDIV;
         end else if (grant_md_c) begin
            rr_ptr <= RR_LOAD;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: hand-derived winners per step, expected
// writes queued at drive time and popped one cycle later.
module tb_wb_port_arbiter;

   logic clk;
   logic rst_n;

   wb_port_arbiter_if #(.XLEN(32)) bus ();

   wb_port_arbiter #(.XLEN(32), .MAX_WAIT(4), .WAIT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [1:0]  src;
   } wr_t;

   wr_t         sb[$];
   int          n_vec;
   int          n_err;
   logic [4:0]  hold_rd;
   logic [31:0] hold_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
      bus.pipe_valid = pv;  bus.pipe_rd = prd; bus.pipe_data = pd;
      bus.ld_valid   = lv;  bus.ld_rd   = lrd; bus.ld_data   = ldat;
      bus.md_valid   = mv;  bus.md_rd   = mrd; bus.md_data   = mdat;
   endtask

   // One cycle: drive, check readies against the expected winner, queue the write,
   // clock, then pop and check the registered write
   task automatic step(input string tag, input logic [1:0] win,
                       input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
      wr_t e;
      wr_t got;
      drive(pv, prd, pd, lv, lrd, ldat, mv, mrd, mdat);
      #1;
      chk({tag, ".pipe_ready"}, 32'(bus.pipe_ready), 32'(win == 2'd1));
      chk({tag, ".ld_ready"},   32'(bus.ld_ready),   32'(win == 2'd2));
      chk({tag, ".md_ready"},   32'(bus.md_ready),   32'(win == 2'd3));
      case (win)
         2'd1:    begin hold_rd = prd; hold_data = pd;   end
         2'd2:    begin hold_rd = lrd; hold_data = ldat; end
         2'd3:    begin hold_rd = mrd; hold_data = mdat; end
         default: ;
      endcase
      e.we   = (win != 2'd0) && (hold_rd != 5'd0);
      e.rd   = hold_rd;
      e.data = hold_data;
      e.src  = win;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      end else begin
         got = sb.pop_front();
         chk({tag, ".rf_we"},    32'(bus.rf_we),  32'(got.we));
         chk({tag, ".rf_rd"},    32'(bus.rf_rd),  32'(got.rd));
         chk({tag, ".rf_wdata"}, bus.rf_wdata,    got.data);
         chk({tag, ".wb_src"},   32'(bus.wb_src), 32'(got.src));
      end
   endtask

   task automatic idle(input string tag);
      step(tag, 2'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".rf_we"},    32'(bus.rf_we),  32'd0);
      chk({tag, ".rf_rd"},    32'(bus.rf_rd),  32'd0);
      chk({tag, ".rf_wdata"}, bus.rf_wdata,    32'd0);
      chk({tag, ".wb_src"},   32'(bus.wb_src), 32'd0);
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      hold_rd   = 5'd0;
      hold_data = 32'd0;
      rst_n     = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1 rst_n = 1'b0;

      // Reset: outputs cleared, readies still follow the arbitration rules
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("rst");
      chk("rst.idle_ready", 32'({bus.pipe_ready, bus.ld_ready, bus.md_ready}), 32'd0);
      bus.pipe_valid = 1'b1;
      #1;
      chk("rst.pipe_ready", 32'(bus.pipe_ready), 32'd1);
      bus.pipe_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 5; i++) idle("idle");

      // Single pipe write
      step("pipe1", 2'd1, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // Load to x0: accepted, no write enable, source still reported; rr_ptr -> md
      step("x0", 2'd2, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);

      // Starvation: pipe wins four times, then mul/div is forced
      for (int i = 0; i < 4; i++)
         step("starve.pipe", 2'd1, 1'b1, 5'(i + 1), 32'h100 + 32'(i),
              1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h55);
      step("starve.forced", 2'd3, 1'b1, 5'd5, 32'h104, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h55);
      step("starve.after", 2'd1, 1'b1, 5'd6, 32'h105, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h66);
      idle("starve.idle");

      // Both slow units forced together: rr_ptr (load) breaks the tie, md follows
      for (int i = 0; i < 4; i++)
         step("both.pipe", 2'd1, 1'b1, 5'd11, 32'h200 + 32'(i),
              1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0);
      step("both.ld", 2'd2, 1'b1, 5'd11, 32'h204, 1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0);
      step("both.md", 2'd3, 1'b1, 5'd11, 32'h204, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hD0);
      step("both.pipe2", 2'd1, 1'b1, 5'd11, 32'h204, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      idle("both.idle");

      // Async reset mid-cycle right after a pipe transfer lands
      step("arst.pipe", 2'd1, 1'b1, 5'd9, 32'h0000_A5A5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs("arst");
      hold_rd   = 5'd0;
      hold_data = 32'd0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Round robin after reset: load first, then alternate
      for (int i = 0; i < 4; i++)
         step("rr", (i % 2 == 0) ? 2'd2 : 2'd3, 1'b0, 5'd0, 32'd0,
              1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);

      // Same rd back-to-back from two sources lands in grant order
      step("same.pipe", 2'd1, 1'b1, 5'd10, 32'h1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      step("same.ld", 2'd2, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h2, 1'b0, 5'd0, 32'd0);
      idle("end");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
